// File: rtl/muldiv_arb_pkg.sv
// ============================================================================
// Module      : muldiv_arb_pkg
// Description : Shared types and helpers for the muldiv_arbiter slice.
//               It defines the functional-unit operation encoding, the
//               fu_data_t issue bundle, the tag table entry type, and the
//               multiply/divide op classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_arb_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [4:0] {
    ADD, MUL, MULH, MULHU, MULHSU, MULW,
    DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW,
    BEXT, BDEP
  } fu_op_t;

  typedef struct packed {
    fu_op_t                   operation;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic                     valid;
    logic                     port;
    logic [TRANS_ID_BITS-1:0] orig_id;
  } tag_entry_t;

  // Ops that occupy the serial divider and must wait for it to be idle.
  function automatic logic is_div_op(fu_op_t op);
    case (op)
      DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW: is_div_op = 1'b1;
      default:                                        is_div_op = 1'b0;
    endcase
  endfunction

  // Ops handled by the pipelined multiplier path, which can accept every cycle.
  function automatic logic is_mul_op(fu_op_t op);
    case (op)
      MUL, MULH, MULHU, MULHSU, MULW, BEXT, BDEP: is_mul_op = 1'b1;
      default:                                     is_mul_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_tag_table.sv
// ============================================================================
// Module      : muldiv_tag_table
// Description : Internal tag pool for the muldiv_arbiter. It stores
//               {valid, port, orig_id} per tag, offers the lowest-index free
//               tag from the registered state, and looks up returning tags.
//               Returns free their entry at the edge. Flush clears every entry.
// Ports       : clk_i/rst_ni       clock, async active-low reset
//               flush_i            clear all valid bits at the edge
//               alloc_*            allocation request and offered tag
//               lookup_*           returning-tag lookup (hit/port/orig_id)
//               free_en_i          release the looked-up tag at the edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_tag_table
  import muldiv_arb_pkg::*;
#(
  parameter int unsigned NR_TAGS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alloc_en_i,
  input  logic                     alloc_port_i,
  input  logic [TRANS_ID_BITS-1:0] alloc_orig_id_i,
  output logic                     alloc_avail_o,
  output logic [TRANS_ID_BITS-1:0] alloc_tag_o,
  input  logic [TRANS_ID_BITS-1:0] lookup_tag_i,
  output logic                     lookup_hit_o,
  output logic                     lookup_port_o,
  output logic [TRANS_ID_BITS-1:0] lookup_orig_id_o,
  input  logic                     free_en_i
);

  tag_entry_t [NR_TAGS-1:0] entries_q, entries_d;

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    alloc_avail_o = 1'b0;
    alloc_tag_o   = '0;
    for (int i = int'(NR_TAGS) - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        alloc_avail_o = 1'b1;
        alloc_tag_o   = TRANS_ID_BITS'(i);
      end
    end
  end

  // Compare against each index so tags at or above NR_TAGS never hit.
  always_comb begin
    lookup_hit_o     = 1'b0;
    lookup_port_o    = 1'b0;
    lookup_orig_id_o = '0;
    for (int i = 0; i < int'(NR_TAGS); i++) begin
      if (lookup_tag_i == TRANS_ID_BITS'(i)) begin
        lookup_hit_o     = entries_q[i].valid;
        lookup_port_o    = entries_q[i].port;
        lookup_orig_id_o = entries_q[i].orig_id;
      end
    end
  end

  // The allocated tag is free in the registered state, so it never collides
  // with the tag released by a return in the same cycle.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < int'(NR_TAGS); i++) begin
      if (free_en_i && (lookup_tag_i == TRANS_ID_BITS'(i))) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc_en_i && (alloc_tag_o == TRANS_ID_BITS'(i))) begin
        entries_d[i].valid   = 1'b1;
        entries_d[i].port    = alloc_port_i;
        entries_d[i].orig_id = alloc_orig_id_i;
      end
      if (flush_i) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_arbiter.sv
// ============================================================================
// Module      : muldiv_arbiter
// Description : Shares one mult unit (pipelined multiplier + serial divider)
//               between two requesters. It grants at most one request per
//               cycle and holds divides back while the divider is busy. It
//               renames trans_id to an internal tag and routes registered
//               results back to the owning port.
// Config      : MULDIV_ARB_FIXED_PRIO_EN - when defined, port 0 wins ties and
//               the round-robin pointer is removed.
// Ports       : clk_i/rst_ni                    clock, async active-low reset
//               flush_i                         squash outstanding operations
//               req_valid_i/req_data_i/req_ready_o  per-port issue handshake
//               unit_data_o/unit_valid_o        issue to mult
//               unit_ready_i                    divider idle flag
//               unit_valid_i/unit_trans_id_i/unit_result_i  mult return
//               res_valid_o/res_trans_id_o/res_data_o  per-port results
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_arbiter
  import muldiv_arb_pkg::*;
#(
  parameter int unsigned NR_TAGS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [1:0]                    req_valid_i,
  input  fu_data_t [1:0]                req_data_i,
  output logic [1:0]                    req_ready_o,
  output fu_data_t                      unit_data_o,
  output logic                          unit_valid_o,
  input  logic                          unit_ready_i,
  input  logic                          unit_valid_i,
  input  logic [TRANS_ID_BITS-1:0]      unit_trans_id_i,
  input  logic [63:0]                   unit_result_i,
  output logic [1:0]                    res_valid_o,
  output logic [1:0][TRANS_ID_BITS-1:0] res_trans_id_o,
  output logic [1:0][63:0]              res_data_o
);

  logic                     tag_avail;
  logic [TRANS_ID_BITS-1:0] alloc_tag;
  logic                     ret_hit;
  logic                     ret_port;
  logic [TRANS_ID_BITS-1:0] ret_orig_id;
  logic                     ret_take;

  logic [1:0]               eligible;
  logic                     grant_valid;
  logic                     grant_port;
  logic                     pref_port;

  logic [1:0]                    res_valid_q, res_valid_d;
  logic [1:0][TRANS_ID_BITS-1:0] res_trans_id_q, res_trans_id_d;
  logic [1:0][63:0]              res_data_q, res_data_d;

  // Only one grant per cycle, so at most one div is ever accepted in a cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid_i[i] & ~flush_i & tag_avail &
                    (is_mul_op(req_data_i[i].operation) |
                     (is_div_op(req_data_i[i].operation) & unit_ready_i));
    end
  end

  always_comb begin
    grant_valid = |eligible;
    grant_port  = (&eligible) ? pref_port : eligible[1];
  end

`ifdef MULDIV_ARB_FIXED_PRIO_EN
  assign pref_port = 1'b0;
`else
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = ~grant_port;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign pref_port = rr_q;
`endif

  always_comb begin
    req_ready_o    = 2'b00;
    unit_valid_o   = grant_valid;
    unit_data_o    = '0;
    if (grant_valid) begin
      req_ready_o[grant_port] = 1'b1;
      unit_data_o             = req_data_i[grant_port];
      unit_data_o.trans_id    = alloc_tag;
    end
  end

  // Stale results (flushed or unknown tags) are dropped without a pulse.
  assign ret_take = unit_valid_i & ~flush_i & ret_hit;

  muldiv_tag_table #(
    .NR_TAGS (NR_TAGS)
  ) u_tag_table (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .alloc_en_i       (grant_valid),
    .alloc_port_i     (grant_port),
    .alloc_orig_id_i  (req_data_i[grant_port].trans_id),
    .alloc_avail_o    (tag_avail),
    .alloc_tag_o      (alloc_tag),
    .lookup_tag_i     (unit_trans_id_i),
    .lookup_hit_o     (ret_hit),
    .lookup_port_o    (ret_port),
    .lookup_orig_id_o (ret_orig_id),
    .free_en_i        (ret_take)
  );

  always_comb begin
    res_valid_d    = 2'b00;
    res_trans_id_d = res_trans_id_q;
    res_data_d     = res_data_q;
    if (ret_take) begin
      res_valid_d[ret_port]    = 1'b1;
      res_trans_id_d[ret_port] = ret_orig_id;
      res_data_d[ret_port]     = unit_result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q    <= '0;
      res_trans_id_q <= '0;
      res_data_q     <= '0;
    end else begin
      res_valid_q    <= res_valid_d;
      res_trans_id_q <= res_trans_id_d;
      res_data_q     <= res_data_d;
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_trans_id_o = res_trans_id_q;
  assign res_data_o     = res_data_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_arbiter.sv
// ============================================================================
// Module      : tb_muldiv_arbiter
// Description : Self-checking bench for muldiv_arbiter. A tag-ownership model
//               predicts grants, renamed issue data and returned results on
//               every cycle. Directed steps pin key values with literals.
// Config      : honours MULDIV_ARB_FIXED_PRIO_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_arbiter;
  import muldiv_arb_pkg::*;

  localparam int NR_TAGS = 4;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic                          flush_i;
  logic [1:0]                    req_valid_i;
  fu_data_t [1:0]                req_data_i;
  logic [1:0]                    req_ready_o;
  fu_data_t                      unit_data_o;
  logic                          unit_valid_o;
  logic                          unit_ready_i;
  logic                          unit_valid_i;
  logic [TRANS_ID_BITS-1:0]      unit_trans_id_i;
  logic [63:0]                   unit_result_i;
  logic [1:0]                    res_valid_o;
  logic [1:0][TRANS_ID_BITS-1:0] res_trans_id_o;
  logic [1:0][63:0]              res_data_o;

  int total = 0;
  int bad   = 0;

  muldiv_arbiter #(.NR_TAGS(NR_TAGS)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_data_i      (req_data_i),
    .req_ready_o     (req_ready_o),
    .unit_data_o     (unit_data_o),
    .unit_valid_o    (unit_valid_o),
    .unit_ready_i    (unit_ready_i),
    .unit_valid_i    (unit_valid_i),
    .unit_trans_id_i (unit_trans_id_i),
    .unit_result_i   (unit_result_i),
    .res_valid_o     (res_valid_o),
    .res_trans_id_o  (res_trans_id_o),
    .res_data_o      (res_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fu_data_t mk(input fu_op_t op, input int tid, input int a, input int b);
    fu_data_t d;
    d           = '0;
    d.operation = op;
    d.operand_a = 64'(a);
    d.operand_b = 64'(b);
    d.imm       = 64'(a + b);
    d.trans_id  = TRANS_ID_BITS'(tid);
    return d;
  endfunction

  function automatic bit mdl_is_mul(input fu_op_t op);
    return op inside {MUL, MULH, MULHU, MULHSU, MULW, BEXT, BDEP};
  endfunction

  function automatic bit mdl_is_div(input fu_op_t op);
    return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
  endfunction

  // ---------------- reference model: who owns which tag ----------------
  bit                       m_valid [NR_TAGS];
  bit                       m_port  [NR_TAGS];
  logic [TRANS_ID_BITS-1:0] m_orig  [NR_TAGS];
  bit                       m_pref;
  logic [1:0]               e_rv;
  logic [TRANS_ID_BITS-1:0] e_rid   [2];
  logic [63:0]              e_rdata [2];

  always @(negedge clk_i) begin : model_cmp
    int       f;
    int       g;
    bit [1:0] el;
    fu_data_t e_ud;
    logic [1:0] e_rdy;
    if (!rst_ni) begin
      for (int i = 0; i < NR_TAGS; i++) m_valid[i] = 0;
      m_pref = 0;
      e_rv   = 2'b00;
    end else begin
      chk("res_valid", 256'(res_valid_o), 256'(e_rv));
      for (int p = 0; p < 2; p++) begin
        if (e_rv[p]) begin
          chk("res_trans_id", 256'(res_trans_id_o[p]), 256'(e_rid[p]));
          chk("res_data", 256'(res_data_o[p]), 256'(e_rdata[p]));
        end
      end
      f = -1;
      for (int i = NR_TAGS - 1; i >= 0; i--) if (!m_valid[i]) f = i;
      for (int p = 0; p < 2; p++) begin
        el[p] = req_valid_i[p] && !flush_i && (f >= 0) &&
                (mdl_is_mul(req_data_i[p].operation) ||
                 (mdl_is_div(req_data_i[p].operation) && unit_ready_i));
      end
`ifdef MULDIV_ARB_FIXED_PRIO_EN
      g = el[0] ? 0 : (el[1] ? 1 : -1);
`else
      g = (el[0] && el[1]) ? int'(m_pref) : (el[0] ? 0 : (el[1] ? 1 : -1));
`endif
      e_rdy = 2'b00;
      e_ud  = '0;
      if (g >= 0) begin
        e_rdy[g]      = 1'b1;
        e_ud          = req_data_i[g];
        e_ud.trans_id = TRANS_ID_BITS'(f);
      end
      chk("req_ready", 256'(req_ready_o), 256'(e_rdy));
      chk("unit_valid", 256'(unit_valid_o), 256'(g >= 0));
      chk("unit_data", 256'(unit_data_o), 256'(e_ud));
      // next-cycle expectations and ownership update
      e_rv = 2'b00;
      if (unit_valid_i && !flush_i && (int'(unit_trans_id_i) < NR_TAGS) &&
          m_valid[unit_trans_id_i]) begin
        e_rv[m_port[unit_trans_id_i]]    = 1'b1;
        e_rid[m_port[unit_trans_id_i]]   = m_orig[unit_trans_id_i];
        e_rdata[m_port[unit_trans_id_i]] = unit_result_i;
        m_valid[unit_trans_id_i]         = 0;
      end
      if (flush_i) for (int i = 0; i < NR_TAGS; i++) m_valid[i] = 0;
      if (g >= 0) begin
        m_valid[f] = 1;
        m_port[f]  = g[0];
        m_orig[f]  = req_data_i[g].trans_id;
        m_pref     = (g == 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ret(input int tag, input int data);
    unit_valid_i    = 1'b1;
    unit_trans_id_i = TRANS_ID_BITS'(tag);
    unit_result_i   = 64'(data);
  endtask

  initial begin
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    req_valid_i     = 2'b00;
    req_data_i      = '0;
    unit_ready_i    = 1'b1;
    unit_valid_i    = 1'b0;
    unit_trans_id_i = '0;
    unit_result_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_res_valid", 256'(res_valid_o), 256'(0));
    chk("rst_res_data", 256'(res_data_o), 256'(0));
    chk("rst_res_tid", 256'(res_trans_id_o), 256'(0));
    chk("rst_req_ready", 256'(req_ready_o), 256'(0));
    chk("rst_unit_valid", 256'(unit_valid_o), 256'(0));
    rst_ni = 1'b1;
    step();

    // Both ports MUL until the pool of four tags is exhausted.
    for (int k = 0; k < 4; k++) begin
      req_valid_i   = 2'b11;
      req_data_i[0] = mk(MUL, 1, 10 + k, 3);
      req_data_i[1] = mk(MULH, 6, 20 + k, 7);
      #1;
      chk("fill_tag", 256'(unit_data_o.trans_id), 256'(k));
`ifdef MULDIV_ARB_FIXED_PRIO_EN
      chk("fill_grant", 256'(req_ready_o), 256'(2'b01));
`else
      chk("fill_grant", 256'(req_ready_o), 256'((k % 2 == 0) ? 2'b01 : 2'b10));
`endif
      step();
    end
    ret(2, 32'h1234);
    #1;
    chk("full_ready", 256'(req_ready_o), 256'(0));
    step();
    unit_valid_i = 1'b0;
    #1;
    chk("refill_ready", 256'(req_ready_o), 256'(2'b01));
    chk("refill_tag", 256'(unit_data_o.trans_id), 256'(2));
    chk("ret2_valid", 256'(res_valid_o), 256'(2'b01));
    chk("ret2_tid", 256'(res_trans_id_o[0]), 256'(1));
    chk("ret2_data", 256'(res_data_o[0]), 256'(32'h1234));
    step();
    req_valid_i = 2'b00;
    for (int t = 0; t < 4; t++) begin
      ret(t, 100 + t);
      step();
    end
    unit_valid_i = 1'b0;
    step();

    // Single MUL on port 0 and its result.
    req_valid_i   = 2'b01;
    req_data_i[0] = mk(MUL, 5, 6, 7);
    #1;
    chk("t1_unit_valid", 256'(unit_valid_o), 256'(1));
    chk("t1_tag", 256'(unit_data_o.trans_id), 256'(0));
    step();
    req_valid_i = 2'b00;
    ret(0, 32'h2A);
    step();
    unit_valid_i = 1'b0;
    #1;
    chk("t1_res_valid", 256'(res_valid_o), 256'(2'b01));
    chk("t1_res_tid", 256'(res_trans_id_o[0]), 256'(5));
    chk("t1_res_data", 256'(res_data_o[0]), 256'(32'h2A));
    step();

    // DIV held while the divider is busy, issued as soon as it idles.
    unit_ready_i  = 1'b0;
    req_valid_i   = 2'b11;
    req_data_i[0] = mk(MULW, 2, 1, 2);
    req_data_i[1] = mk(DIV, 3, 100, 7);
    #1;
    chk("div_busy_grant", 256'(req_ready_o), 256'(2'b01));
    step();
    req_valid_i  = 2'b10;
    unit_ready_i = 1'b1;
    #1;
    chk("div_idle_grant", 256'(req_ready_o), 256'(2'b10));
    chk("div_idle_op", 256'(unit_data_o.operation), 256'(DIV));
    step();

    // Two divides in one cycle: only one may go.
    req_valid_i   = 2'b11;
    req_data_i[0] = mk(REMU, 4, 9, 4);
    req_data_i[1] = mk(DIVU, 7, 8, 2);
    #1;
    chk("two_div_one_grant", 256'($countones(req_ready_o)), 256'(1));
    step();
    req_valid_i = 2'b00;

    // Flush with tags outstanding, then a stale return.
    flush_i       = 1'b1;
    req_valid_i   = 2'b01;
    req_data_i[0] = mk(MUL, 3, 5, 5);
    #1;
    chk("flush_block", 256'(req_ready_o), 256'(0));
    step();
    flush_i = 1'b0;
    ret(1, 32'hDEAD);
    #1;
    chk("post_flush_tag", 256'(unit_data_o.trans_id), 256'(0));
    step();
    ret(0, 32'h55);
    req_data_i[0] = mk(BEXT, 4, 3, 1);
    #1;
    chk("stale_dropped", 256'(res_valid_o), 256'(0));
    chk("ret_and_issue_tag", 256'(unit_data_o.trans_id), 256'(1));
    step();
    req_valid_i = 2'b00;
    ret(7, 32'hBEEF);
    #1;
    chk("flush_res_valid", 256'(res_valid_o), 256'(2'b01));
    chk("flush_res_tid", 256'(res_trans_id_o[0]), 256'(3));
    chk("flush_res_data", 256'(res_data_o[0]), 256'(32'h55));
    step();
    unit_valid_i = 1'b0;
    #1;
    chk("oor_dropped", 256'(res_valid_o), 256'(0));
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares the single `mult` functional unit (pipelined multiplier plus serial divider) between two issue requesters, such as two issue lanes or an issue lane and a coprocessor port. It arbitrates issue, holds divides back while the divider is busy, and renames each requester's `trans_id` to an internal tag so results route back to their owner. It sits between the requesters and the `mult` instance and drives its `fu_data_i`/`mult_valid_i`.

## Interface
- `NR_TAGS`, default 4: internal tag pool size; 2 ≤ `NR_TAGS` ≤ 2^`TRANS_ID_BITS`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: squash all outstanding operations.
- `req_valid_i` in [1:0]: per-port request valid.
- `req_data_i` in fu_data_t[1:0]: per-port operation; `trans_id` is the requester's own ID.
- `req_ready_o` out [1:0]: per-port accept, combinational.
- `unit_data_o` out fu_data_t: to `mult.fu_data_i`; `trans_id` carries the internal tag.
- `unit_valid_o` out 1: to `mult.mult_valid_i`.
- `unit_ready_i` in 1: from `mult.mult_ready_o`, the divider idle flag.
- `unit_valid_i` in 1: from `mult.mult_valid_o`.
- `unit_trans_id_i` in TRANS_ID_BITS: returned internal tag.
- `unit_result_i` in 64: returned result.
- `res_valid_o` out [1:0]: per-port result pulse; no backpressure.
- `res_trans_id_o` out TRANS_ID_BITS[1:0]: the requester's original `trans_id`.
- `res_data_o` out 64[1:0]: result.

## Operation
**Tag table.** `NR_TAGS` entries, each {valid, port, orig_id}.
- Allocation takes the lowest-index entry whose valid bit is 0 in the registered state.
- A tag freed this cycle becomes allocatable next cycle.

**Eligibility.** Port i is eligible when all of the following hold:
- `req_valid_i[i]`
- not `flush_i`
- a free tag exists
- the op is a multiply-class op (MUL, MULH, MULHU, MULHSU, MULW, BEXT, BDEP), or it is a div-class op (DIV* or REM*) and `unit_ready_i` is 1 and no div is already accepted this cycle.

**Arbitration.**
- At most one grant per cycle.
- Round-robin pointer `rr_q` names the preferred port. If both ports are eligible, grant `rr_q`; otherwise grant the single eligible port.
- After a grant, `rr_q` moves to the other port.

**Issue on grant.**
- `req_ready_o[g]` = 1 and `unit_valid_o` = 1.
- `unit_data_o` = `req_data_i[g]` with `trans_id` replaced by the allocated tag.
- The entry is written {1, g, orig trans_id}.
- With no grant, `unit_valid_o` = 0 and `unit_data_o` = '0.

**Return.**
- When `unit_valid_i` and `entry[unit_trans_id_i].valid` are both set, register `res_valid_o[port]` = 1 with that port's orig_id and data, and clear the entry.
- Returns carrying an invalid or out-of-range tag are dropped silently (stale multiplier results after a flush).

**Flush.**
- Clears every valid bit at the clock edge.
- Blocks grants in the flush cycle.
- Drops any return arriving in the flush cycle.
- Registered results already in `res_*_o` still present for their cycle.

**Reset.**
- Table empty, `rr_q` = 0.
- `res_valid_o` = 0, `res_data_o` = 0, `res_trans_id_o` = 0.
- Combinational outputs follow their equations: `req_ready_o`/`unit_valid_o` are 0 while inputs are idle.

## Timing
- Issue latency is 0: accept and unit issue happen in the same cycle.
- Return latency is 1: `res_valid_o` is asserted the cycle after `unit_valid_i` and lasts exactly one cycle per result.
- The table is full when all `NR_TAGS` entries are valid. Both ports then see `req_ready_o` = 0 until a return frees an entry; the freed entry is usable one cycle after the return.
- At most one result returns per cycle, since the unit muxes internally. `res_valid_o` is therefore one-hot or zero.
- Simultaneous return and issue: the return frees its tag at the edge, and the issue allocates a different, already-free tag.
- A div issued while `unit_ready_i` = 0 is illegal; the eligibility rule prevents it.

## Configuration
- `MULDIV_ARB_FIXED_PRIO_EN` defined: port 0 always wins when both ports are eligible, and `rr_q` is removed.
- Not defined: round-robin as above.

## Structure
- Shared package `muldiv_arb_pkg` holds:
  - `tag_entry_t` {logic valid; logic port; logic [TRANS_ID_BITS-1:0] orig_id}
  - `is_div_op(fu_op)` function
  - `is_mul_op(fu_op)` function
- One sub-module, `muldiv_tag_table`: storage, lowest-free allocation, free-on-return and flush clear. Arbitration and result registers stay in the top.

## Test plan
- Port 0 MUL, tid 5, with an idle unit → `unit_valid_o` = 1, `unit_data_o.trans_id` = 0; a unit return of tag 0 with 0x2A → next cycle `res_valid_o` = 2'b01, `res_trans_id_o[0]` = 5, data 0x2A.
- Both ports MUL every cycle for 4 cycles (`NR_TAGS` = 4, no returns) → grants alternate 0,1,0,1 with tags 0..3. Fifth cycle: `req_ready_o` = 0. After one return, the next cycle grants again with the freed tag.
- Port 1 DIV with `unit_ready_i` = 0 and port 0 MUL → port 0 granted, port 1 held. When `unit_ready_i` rises, DIV issues the same cycle.
- Two DIVs on both ports in the same cycle with `unit_ready_i` = 1 → exactly one granted.
- Outstanding tags 0,1 then `flush_i` → table empty. A late return with tag 1 produces no `res_valid_o`, and a new request gets tag 0.
- With `MULDIV_ARB_FIXED_PRIO_EN`, both ports MUL continuously → port 0 granted every cycle.
